// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a mid-bit sampling FSM, consumer
// handshake (data_ready / rx_ack), overrun and framing-error flags.
// All decisions are taken on the synchronised line rx_s.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data_in,
    input  logic       rx_ack,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    // Synchroniser; rx_s is the second flop and the only view of the line.
    logic sync1_r;
    logic rx_s;

    state_t           state_r,   state_n;
    logic [CNT_W-1:0] cnt_r,     cnt_n;
    logic [2:0]       bit_idx_r, bit_idx_n;
    logic [7:0]       shift_r,   shift_n;

    logic [7:0] data_r,       data_n;
    logic       data_valid_r, data_valid_n;
    logic       data_ready_r, data_ready_n;
    logic       frame_err_r,  frame_err_n;
    logic       overrun_r,    overrun_n;
    logic       busy_r;

    logic good_frame_s;
    logic bad_stop_s;

    // Two-flop synchroniser on the asynchronous serial line (idle high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync1_r <= data_in;
            rx_s    <= sync1_r;
        end
    end

    // Next-state logic: bit timing, sampling and stop-bit qualification.
    always_comb begin
        state_n      = state_r;
        cnt_n        = cnt_r;
        bit_idx_n    = bit_idx_r;
        shift_n      = shift_r;
        good_frame_s = 1'b0;
        bad_stop_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_n     = CNT_ZERO;
                bit_idx_n = 3'd0;
                if (!rx_s) begin
                    state_n = ST_START;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == CNT_HALF) begin
                    cnt_n     = CNT_ZERO;
                    bit_idx_n = 3'd0;
                    // Still low at mid start bit: genuine start, else a glitch.
                    if (!rx_s) begin
                        state_n = ST_DATA;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    cnt_n = cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_n              = CNT_ZERO;
                    shift_n[bit_idx_r] = rx_s;
                    if (bit_idx_r == 3'd7) begin
                        bit_idx_n = 3'd0;
                        state_n   = ST_STOP;
                    end else begin
                        bit_idx_n = bit_idx_r + 3'd1;
                    end
                end else begin
                    cnt_n = cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_n = CNT_ZERO;
                    if (rx_s) begin
                        good_frame_s = 1'b1;
                        state_n      = ST_IDLE;
                    end else begin
                        bad_stop_s = 1'b1;
                        state_n    = ST_BREAK;
                    end
                end else begin
                    cnt_n = cnt_r + CNT_ONE;
                end
            end
            ST_BREAK: begin
                // Line must return high before a new start can be seen.
                cnt_n = CNT_ZERO;
                if (rx_s) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_BREAK;
                end
            end
            default: begin
                state_n   = ST_IDLE;
                cnt_n     = CNT_ZERO;
                bit_idx_n = 3'd0;
            end
        endcase
    end

    // Consumer-facing flags: frame completion and acknowledge handling.
    always_comb begin
        data_n       = data_r;
        data_valid_n = 1'b0;
        data_ready_n = data_ready_r;
        frame_err_n  = frame_err_r;
        overrun_n    = overrun_r;
        if (good_frame_s) begin
            data_n       = shift_r;
            data_valid_n = 1'b1;
            data_ready_n = 1'b1;
            frame_err_n  = 1'b0;
            // An ack in the same cycle consumes the old byte, so no overrun.
            if (rx_ack) begin
                overrun_n = 1'b0;
            end else begin
                overrun_n = overrun_r | data_ready_r;
            end
        end else if (bad_stop_s) begin
            frame_err_n = 1'b1;
            if (rx_ack) begin
                data_ready_n = 1'b0;
                overrun_n    = 1'b0;
            end else begin
                data_ready_n = data_ready_r;
                overrun_n    = overrun_r;
            end
        end else if (rx_ack) begin
            data_ready_n = 1'b0;
            overrun_n    = 1'b0;
            frame_err_n  = 1'b0;
        end else begin
            data_ready_n = data_ready_r;
        end
    end

    // FSM state, counters and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            state_r   <= state_n;
            cnt_r     <= cnt_n;
            bit_idx_r <= bit_idx_n;
            shift_r   <= shift_n;
        end
    end

    // Registered outputs; busy tracks the state register exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r       <= 8'h00;
            data_valid_r <= 1'b0;
            data_ready_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            data_r       <= data_n;
            data_valid_r <= data_valid_n;
            data_ready_r <= data_ready_n;
            frame_err_r  <= frame_err_n;
            overrun_r    <= overrun_n;
            busy_r       <= (state_n != ST_IDLE);
        end
    end

    assign data       = data_r;
    assign data_valid = data_valid_r;
    assign data_ready = data_ready_r;
    assign frame_err  = frame_err_r;
    assign overrun    = overrun_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. Stimulus pushes the expected
// byte, completion cycle and overrun flag; a monitor pops on data_valid.
module tb_uart_rx;

    localparam int N   = 16;
    localparam int H   = N / 2;
    // 2 synchroniser edges + 1 edge into START, then half a bit + 9 bits.
    localparam int LAT = 3 + H + 9 * N;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       data_in;
    logic       ack_man = 1'b0;
    logic       ack_auto = 1'b0;
    logic       rx_ack;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    assign rx_ack = ack_man | ack_auto;

    uart_rx #(.CLKS_PER_BIT(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .rx_ack     (rx_ack),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        int         at;
        logic       ovr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   auto_ack = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every data_valid pulse is checked against the scoreboard head.
    always @(negedge clk) begin
        ack_auto = 1'b0;
        if (rst_n === 1'b1 && data_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got data %0h, want no output", data);
            end else begin
                mon_e = sb.pop_front();
                chk("data",      {24'h0, data}, {24'h0, mon_e.d});
                chk("latency",   cyc, mon_e.at);
                chk("ready",     {31'h0, data_ready}, 32'd1);
                chk("frame_err", {31'h0, frame_err}, 32'd0);
                chk("overrun",   {31'h0, overrun}, {31'h0, mon_e.ovr});
            end
            ack_auto = auto_ack;
        end
    end

    task automatic drive_bit(input logic v, input int n);
        data_in = v;
        repeat (n) @(negedge clk);
    endtask

    // Sends one 8N1 frame LSB first; a good stop bit registers an expectation.
    task automatic send(input logic [7:0] b, input logic stop_ok, input logic exp_ovr);
        exp_t e;
        if (stop_ok) begin
            e.d   = b;
            e.at  = cyc + LAT;
            e.ovr = exp_ovr;
            sb.push_back(e);
        end
        drive_bit(1'b0, N);
        for (int i = 0; i < 8; i++) drive_bit(b[i], N);
        drive_bit(stop_ok, N);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("drain", sb.size(), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic ack_pulse();
        ack_man = 1'b1;
        @(negedge clk);
        ack_man = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        int          k;
        logic [7:0]  b;
        int          gap;
        logic        ok;

        data_in = 1'b1;
        rst_n   = 1'b0;
        #12;
        chk("rst_data",  {24'h0, data}, 32'h00);
        chk("rst_valid", {31'h0, data_valid}, 32'd0);
        chk("rst_ready", {31'h0, data_ready}, 32'd0);
        chk("rst_ferr",  {31'h0, frame_err}, 32'd0);
        chk("rst_ovr",   {31'h0, overrun}, 32'd0);
        chk("rst_busy",  {31'h0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Basic frame.
        send(8'hA5, 1'b1, 1'b0);
        drain();
        chk("a5_ready", {31'h0, data_ready}, 32'd1);
        ack_pulse();
        chk("a5_ack_ready", {31'h0, data_ready}, 32'd0);

        // False start: 4 low cycles.
        drive_bit(1'b0, 4);
        chk("fs_busy_hi", {31'h0, busy}, 32'd1);
        drive_bit(1'b1, 8);
        chk("fs_busy_lo", {31'h0, busy}, 32'd0);
        chk("fs_data",    {24'h0, data}, 32'hA5);

        // Framing error followed by a break, then a good frame.
        send(8'h3C, 1'b0, 1'b0);
        drive_bit(1'b0, 40);
        chk("fe_set",   {31'h0, frame_err}, 32'd1);
        chk("fe_busy",  {31'h0, busy}, 32'd1);
        chk("fe_data",  {24'h0, data}, 32'hA5);
        chk("fe_ready", {31'h0, data_ready}, 32'd0);
        drive_bit(1'b1, N);
        chk("brk_exit", {31'h0, busy}, 32'd0);
        send(8'h5A, 1'b1, 1'b0);
        drain();
        ack_pulse();

        // Back-to-back frames without acknowledge: overrun.
        send(8'h11, 1'b1, 1'b0);
        send(8'h22, 1'b1, 1'b1);
        drain();
        chk("ovr_data", {24'h0, data}, 32'h22);
        chk("ovr_set",  {31'h0, overrun}, 32'd1);
        ack_pulse();
        chk("ovr_ready_clr", {31'h0, data_ready}, 32'd0);
        chk("ovr_clr",       {31'h0, overrun}, 32'd0);

        // Acknowledge coinciding with completion of a new good frame.
        send(8'h33, 1'b1, 1'b0);
        drain();
        k = cyc;
        fork
            send(8'h44, 1'b1, 1'b0);
            begin
                while (cyc != k + LAT - 1) @(negedge clk);
                ack_man = 1'b1;
                @(negedge clk);
                ack_man = 1'b0;
            end
        join
        drain();
        chk("coinc_ready", {31'h0, data_ready}, 32'd1);
        chk("coinc_ovr",   {31'h0, overrun}, 32'd0);

        // Reset during data bit 3.
        b = 8'h96;
        drive_bit(1'b0, N);
        for (int i = 0; i < 3; i++) drive_bit(b[i], N);
        drive_bit(b[3], 8);
        rst_n = 1'b0;
        #1;
        chk("mr_data",  {24'h0, data}, 32'h00);
        chk("mr_valid", {31'h0, data_valid}, 32'd0);
        chk("mr_ready", {31'h0, data_ready}, 32'd0);
        chk("mr_ferr",  {31'h0, frame_err}, 32'd0);
        chk("mr_ovr",   {31'h0, overrun}, 32'd0);
        chk("mr_busy",  {31'h0, busy}, 32'd0);
        @(negedge clk);
        data_in = 1'b1;
        rst_n   = 1'b1;
        repeat (2 * N) @(negedge clk);
        chk("mr_idle", {31'h0, busy}, 32'd0);
        send(8'hFF, 1'b1, 1'b0);
        drain();
        ack_pulse();

        // Randomised frames, auto-acknowledged, random gaps and bad stops.
        auto_ack = 1'b1;
        for (int i = 0; i < 24; i++) begin
            b   = 8'($urandom_range(0, 255));
            ok  = ($urandom_range(0, 4) != 0);
            gap = $urandom_range(0, 2 * N);
            if (!ok && gap < N) gap = N;
            send(b, ok, 1'b0);
            drive_bit(1'b1, gap);
        end
        drain();
        auto_ack = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; must be an even value of at least 4.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 data_in  input  1  asynchronous serial line; idle high; 8N1 framing, LSB first.
REQ-005 rx_ack  input  1  consumer acknowledge; clears data_ready and overrun.
REQ-006 data  output  8  last correctly framed byte.
REQ-007 data_valid  output  1  one-cycle pulse when data is updated.
REQ-008 data_ready  output  1  level; byte waiting for the consumer.
REQ-009 frame_err  output  1  stop bit sampled low on the last frame.
REQ-010 overrun  output  1  sticky; a byte completed while data_ready was already 1.
REQ-011 busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 data_in shall pass through a 2-flop synchronizer (both flops reset to 1); rx_s denotes the second flop; all decisions use rx_s only.
REQ-013 States are IDLE, START, DATA, STOP and BREAK, with a cycle counter and a 3-bit bit index.
REQ-014 IDLE: counter held at 0; rx_s==0 -> START with counter 0.
REQ-015 START: counter increments; at counter==CLKS_PER_BIT/2-1, rx_s==0 -> DATA (counter 0, bit index 0); rx_s==1 -> IDLE as a false start, with no output change.
REQ-016 DATA: counter increments; at counter==CLKS_PER_BIT-1, rx_s is written into shift bit [bit index] and counter goes to 0; after bit index 7 -> STOP.
REQ-017 STOP: at counter==CLKS_PER_BIT-1, rx_s==1 -> data<=shift, data_valid=1 for one cycle, data_ready<=1, frame_err<=0, next state IDLE.
REQ-018 STOP with rx_s==0 at sample -> frame_err<=1; data, data_valid and data_ready unchanged; next state BREAK.
REQ-019 BREAK: remain until rx_s==1, then IDLE; no start detection while in BREAK.
REQ-020 Latency: data_valid shall be asserted at the edge 8+9*CLKS_PER_BIT... precisely CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the edge entering START (152 at default).
REQ-021 Overrun: a good frame completing while data_ready==1 and rx_ack==0 sets overrun; data is still overwritten with the new byte.
REQ-022 rx_ack==1: data_ready<=0 and overrun<=0 next edge.
REQ-023 rx_ack coinciding with good-frame completion: data_ready stays 1; overrun is not set.
REQ-024 frame_err shall be cleared by rx_ack or by the next good frame.
REQ-025 Back-to-back frames (start bit immediately after stop bit) shall be received with no lost byte.
REQ-026 Counter and bit index shall never exceed CLKS_PER_BIT-1 and 7 respectively; no wrap-around leaves a state.

Reset
REQ-027 rst_n low shall immediately force: state IDLE, counter 0, bit index 0, shift 0, data 0x00, data_valid 0, data_ready 0, frame_err 0, overrun 0, busy 0, synchronizer flops 1.
REQ-028 Reset mid-frame shall discard the partial byte; after release, the block waits in IDLE for a new falling edge.

Verification
REQ-029 0xA5, 16 clk/bit, good stop -> one data_valid pulse 152 cycles after START entry; data=0xA5; data_ready=1; frame_err=0.
REQ-030 data_in low for 4 cycles then high -> return to IDLE from START; no data_valid; busy low again within 8 cycles of returning high.
REQ-031 0x3C with stop bit low, line held low 40 more cycles then high -> frame_err=1; data unchanged; no data_valid; BREAK until high, then a following 0x5A received.
REQ-032 0x11 then 0x22 back-to-back, no rx_ack -> data=0x22, overrun=1; then rx_ack pulse -> data_ready=0, overrun=0.
REQ-033 rst_n pulsed low during data bit 3 -> all outputs reset values at once; next frame 0xFF received correctly.
REQ-034 rx_ack asserted in the exact cycle a new good frame completes -> data_ready=1, overrun=0.
